// File: rtl/eth_rx_frame_len_tracker.sv
// RX AXIS pass-through that counts bytes per frame and queues each frame length in a FWFT FIFO.
// Zero-latency data path; stalls only a frame-closing beat while the length FIFO is full.
module eth_rx_frame_len_tracker #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned LenWidth     = 16,
  parameter int unsigned LenFifoDepth = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [DataWidth-1:0]            s_tdata_i,
  input  logic [DataWidth/8-1:0]          s_tkeep_i,
  input  logic                            s_tlast_i,
  input  logic                            s_tvalid_i,
  output logic                            s_tready_o,
  output logic [DataWidth-1:0]            m_tdata_o,
  output logic [DataWidth/8-1:0]          m_tkeep_o,
  output logic                            m_tlast_o,
  output logic                            m_tvalid_o,
  input  logic                            m_tready_i,
  output logic                            len_valid_o,
  output logic [LenWidth-1:0]             len_o,
  output logic                            len_oversize_o,
  input  logic                            len_ready_i,
  output logic [31:0]                     frame_cnt_o,
  output logic [$clog2(LenFifoDepth):0]   fifo_level_o
);
  localparam int unsigned KeepWidth = DataWidth / 8;
  localparam int unsigned PtrWidth  = $clog2(LenFifoDepth);
  localparam int unsigned LvlWidth  = PtrWidth + 1;
  localparam int unsigned SumWidth  = LenWidth + 1;

  typedef struct packed {
    logic                oversize;
    logic [LenWidth-1:0] len;
  } len_entry_t;

  logic [LenWidth-1:0] acc_q, acc_d;
  logic                ovs_q, ovs_d;
  len_entry_t          mem_q [LenFifoDepth];
  len_entry_t          mem_d [LenFifoDepth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlWidth-1:0] level_q, level_d;
  logic [31:0]         frame_cnt_q, frame_cnt_d;

  logic                fifo_full, fifo_empty, blk;
  logic                beat_acc, push, pop, overflow;
  logic [SumWidth-1:0] byte_cnt, sum;
  logic [LenWidth-1:0] sum_sat;

  // Full comes from the registered level only, so a same-cycle pop cannot reach s_tready_o.
  assign fifo_full  = (level_q == LvlWidth'(LenFifoDepth));
  assign fifo_empty = (level_q == '0);
  assign blk        = s_tlast_i & fifo_full;

  assign m_tdata_o  = s_tdata_i;
  assign m_tkeep_o  = s_tkeep_i;
  assign m_tlast_o  = s_tlast_i;
  assign m_tvalid_o = s_tvalid_i & ~blk;
  assign s_tready_o = m_tready_i & ~blk;

  assign beat_acc = s_tvalid_i & s_tready_o;
  assign push     = beat_acc & s_tlast_i;
  assign pop      = ~fifo_empty & len_ready_i;

  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < KeepWidth; i++) begin
      byte_cnt = byte_cnt + SumWidth'(s_tkeep_i[i]);
    end
  end

  assign sum      = {1'b0, acc_q} + byte_cnt;
  assign overflow = sum[LenWidth];
  assign sum_sat  = overflow ? '1 : sum[LenWidth-1:0];

  always_comb begin
    acc_d       = acc_q;
    ovs_d       = ovs_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;

    if (clear_i) begin
      acc_d       = '0;
      ovs_d       = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      frame_cnt_d = '0;
    end else begin
      if (beat_acc) begin
        if (s_tlast_i) begin
          mem_d[wr_ptr_q] = '{oversize: ovs_q | overflow, len: sum_sat};
          wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
          acc_d           = '0;
          ovs_d           = 1'b0;
          frame_cnt_d     = frame_cnt_q + 32'd1;
        end else begin
          acc_d = sum_sat;
          ovs_d = ovs_q | overflow;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LvlWidth'(1);
        2'b01:   level_d = level_q - LvlWidth'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      ovs_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < LenFifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      ovs_q       <= ovs_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      mem_q       <= mem_d;
    end
  end

  // Storage is not cleared, so the head is masked while empty.
  assign len_valid_o    = ~fifo_empty;
  assign len_o          = fifo_empty ? '0 : mem_q[rd_ptr_q].len;
  assign len_oversize_o = fifo_empty ? 1'b0 : mem_q[rd_ptr_q].oversize;
  assign frame_cnt_o    = frame_cnt_q;
  assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_eth_rx_frame_len_tracker.sv
// Scoreboard bench: two instances (16-bit and 4-bit length counters) share one stimulus stream.
module tb_eth_rx_frame_len_tracker;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast, s_tvalid, m_tready, len_ready;

  logic        s_tready, m_tlast, m_tvalid, len_valid, len_ovs;
  logic [31:0] m_tdata, frame_cnt;
  logic [3:0]  m_tkeep;
  logic [15:0] len;
  logic [2:0]  level;

  logic        s_tready4, m_tlast4, m_tvalid4, len_valid4, len_ovs4;
  logic [31:0] m_tdata4, frame_cnt4;
  logic [3:0]  m_tkeep4, len4;
  logic [2:0]  level4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_q[$];
  int          m_acc = 0;
  int unsigned m_fcnt = 0;

  always #5 clk = ~clk;

  eth_rx_frame_len_tracker #(.DataWidth(32), .LenWidth(16), .LenFifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .s_tdata_i(s_tdata), .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast), .s_tvalid_i(s_tvalid),
    .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tlast_o(m_tlast), .m_tvalid_o(m_tvalid),
    .m_tready_i(m_tready),
    .len_valid_o(len_valid), .len_o(len), .len_oversize_o(len_ovs), .len_ready_i(len_ready),
    .frame_cnt_o(frame_cnt), .fifo_level_o(level)
  );

  eth_rx_frame_len_tracker #(.DataWidth(32), .LenWidth(4), .LenFifoDepth(DEPTH)) dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .s_tdata_i(s_tdata), .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast), .s_tvalid_i(s_tvalid),
    .s_tready_o(s_tready4),
    .m_tdata_o(m_tdata4), .m_tkeep_o(m_tkeep4), .m_tlast_o(m_tlast4), .m_tvalid_o(m_tvalid4),
    .m_tready_i(m_tready),
    .len_valid_o(len_valid4), .len_o(len4), .len_oversize_o(len_ovs4), .len_ready_i(len_ready),
    .frame_cnt_o(frame_cnt4), .fifo_level_o(level4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_len_valid"}, {len_valid, len_valid4}, 0);
    check({tag, "_len"}, {len, len_ovs, len4, len_ovs4}, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_level"}, {level, level4}, 0);
  endtask

  // One clock: drive at posedge+1, check at the falling edge, advance the model, wait for the edge.
  task automatic cycle(input logic vld, input logic [3:0] keep, input logic last,
                       input logic lrdy, input logic clr = 1'b0, input logic mrdy = 1'b1);
    logic exp_blk, exp_rdy;
    int   flen;
    s_tvalid  = vld;
    s_tkeep   = keep;
    s_tlast   = last;
    len_ready = lrdy;
    clear     = clr;
    m_tready  = mrdy;
    s_tdata   = $urandom;
    #4;
    exp_blk = last & (exp_q.size() == DEPTH);
    exp_rdy = mrdy & ~exp_blk;
    check("s_tready", {s_tready, s_tready4}, {exp_rdy, exp_rdy});
    check("m_tvalid", {m_tvalid, m_tvalid4}, {vld & ~exp_blk, vld & ~exp_blk});
    check("passthru", {m_tdata, m_tkeep, m_tlast}, {s_tdata, s_tkeep, s_tlast});
    check("level", {level, level4}, {3'(exp_q.size()), 3'(exp_q.size())});
    check("frame_cnt", frame_cnt, m_fcnt);
    check("len_valid", {len_valid, len_valid4}, {exp_q.size() > 0, exp_q.size() > 0});
    if (exp_q.size() == 0) begin
      check("len_empty", {len, len_ovs, len4, len_ovs4}, 0);
    end else if (lrdy) begin
      flen = exp_q.pop_front();
      check("len16", {len_ovs, len}, {1'b0, 16'(flen)});
      check("len4", {len_ovs4, len4}, {flen > 15, (flen > 15) ? 4'hF : 4'(flen)});
    end
    if (clr) begin
      exp_q.delete();
      m_acc  = 0;
      m_fcnt = 0;
    end else if (vld && exp_rdy) begin
      m_acc += $countones(keep);
      if (last) begin
        exp_q.push_back(m_acc);
        m_acc = 0;
        m_fcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b1; len_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(0, 4'h0, 0, 0);

    // 3-beat frame, 10 bytes
    cycle(1, 4'hF, 0, 0); cycle(1, 4'hF, 0, 0); cycle(1, 4'h3, 1, 0);
    cycle(0, 4'h0, 0, 0);
    cycle(0, 4'h0, 0, 1);

    // Fill FIFO (incl. non-contiguous keep and a zero-length frame), then stall a 5th frame end
    cycle(1, 4'hF, 1, 0); cycle(1, 4'h5, 1, 0); cycle(1, 4'h8, 1, 0); cycle(1, 4'h0, 1, 0);
    cycle(1, 4'h3, 1, 0); cycle(1, 4'h3, 1, 0);
    cycle(1, 4'h3, 1, 1);
    cycle(1, 4'h3, 1, 0);
    repeat (5) cycle(0, 4'h0, 0, 1);

    // Downstream backpressure on a non-last beat
    cycle(1, 4'hF, 0, 0, 0, 0); cycle(1, 4'hF, 0, 0); cycle(1, 4'h1, 1, 0);
    cycle(0, 4'h0, 0, 1);

    // 20-byte frame saturates the 4-bit counter; the next frame starts clean
    repeat (4) cycle(1, 4'hF, 0, 0);
    cycle(1, 4'hF, 1, 0);
    cycle(1, 4'h3, 1, 0);
    repeat (2) cycle(0, 4'h0, 0, 1);

    // Simultaneous push and pop at level 2
    cycle(1, 4'h1, 1, 0); cycle(1, 4'h7, 1, 0);
    cycle(1, 4'hE, 1, 1);
    repeat (3) cycle(0, 4'h0, 0, 1);

    // Mid-frame clear after 2 of 4 beats
    cycle(1, 4'h3, 1, 0);
    cycle(1, 4'hF, 0, 0); cycle(1, 4'hF, 0, 0);
    cycle(0, 4'h0, 0, 0, 1);
    cycle(1, 4'hF, 0, 0); cycle(1, 4'hF, 1, 0);
    cycle(0, 4'h0, 0, 1);

    // Asynchronous reset mid-frame with entries queued
    cycle(1, 4'h3, 1, 0); cycle(1, 4'hF, 0, 0);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0;
    rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_q.delete(); m_acc = 0; m_fcnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, 4'h7, 1, 0);
    cycle(0, 4'h0, 0, 1);
    cycle(0, 4'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_len_tracker.md
Name: eth_rx_frame_len_tracker

Overview:
- Sits on the RX AXI-Stream path between the RX CDC FIFO output and the iDMA backend's AXIS read port.
- Passes beats through unchanged and counts bytes per frame from tkeep/tlast.
- Pushes each completed frame length into a small length FIFO that software or a descriptor sequencer pops to size the iDMA transfer.
- Backpressures the stream only when the length FIFO cannot accept a frame-closing beat.

Parameters:
DataWidth, 32, AXIS tdata width in bits; multiple of 8.
LenWidth, 16, frame length counter width in bytes.
LenFifoDepth, 4, number of frame-length entries; power of two, >= 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous clear of accumulator, FIFO and counters
s_tdata_i  in  DataWidth  upstream data
s_tkeep_i  in  DataWidth/8  upstream byte enables
s_tlast_i  in  1  upstream end of frame
s_tvalid_i  in  1  upstream valid
s_tready_o  out  1  upstream ready
m_tdata_o  out  DataWidth  downstream data
m_tkeep_o  out  DataWidth/8  downstream byte enables
m_tlast_o  out  1  downstream end of frame
m_tvalid_o  out  1  downstream valid
m_tready_i  in  1  downstream ready
len_valid_o  out  1  FIFO head valid
len_o  out  LenWidth  head frame length in bytes
len_oversize_o  out  1  head frame exceeded 2^LenWidth-1 bytes
len_ready_i  in  1  pop head
frame_cnt_o  out  32  frames pushed since reset/clear; wraps
fifo_level_o  out  $clog2(LenFifoDepth)+1  occupied entries

Behaviour:
- Reset (rst_i=1, async): accumulator=0, sticky oversize=0, FIFO empty, frame_cnt_o=0, fifo_level_o=0, len_valid_o=0. len_o/len_oversize_o=0 when empty.
- Data path is combinational, zero latency: m_tdata/tkeep/tlast = s_*.
- blk = s_tlast_i & fifo_full, where fifo_full is derived from the registered level.
- m_tvalid_o = s_tvalid_i & ~blk; s_tready_o = m_tready_i & ~blk.
- A pop in the same cycle does not unblock a push when full. This avoids a len_ready_i -> s_tready_o path.
- Accepted beat: s_tvalid_i & s_tready_o.
- bytes = popcount(s_tkeep_i). Bits are not required to be contiguous; tkeep=0 contributes 0.
- sum = acc + bytes, computed at LenWidth+1 bits. If sum > 2^LenWidth-1: saturate to all-ones and set sticky oversize.
- Accepted non-last beat: acc <= saturated sum; oversize |= overflow.
- Accepted last beat:
  - Push {saturated sum, oversize|overflow} into the FIFO.
  - acc <= 0, oversize <= 0, frame_cnt_o += 1 (mod 2^32).
- Zero-length frame (single last beat with tkeep=0, acc=0) pushes length 0.
- FIFO:
  - First-word-fall-through; len_valid_o = ~empty.
  - Pop on len_valid_o & len_ready_i; len_ready_i while empty is ignored.
  - Simultaneous push and pop when not full: level unchanged, ordering preserved.
  - Pointers wrap modulo LenFifoDepth.
- clear_i has priority over all same-cycle updates:
  - acc, oversize, FIFO and frame_cnt_o are zeroed next cycle. A push or pop in that cycle is discarded.
  - The stream is not blocked by clear_i.
  - Clear mid-frame: the remaining beats of that frame are counted as a new frame.
- Reset mid-frame: identical to clear, applied asynchronously.
- Only non-stalled outputs are combinational; all state updates occur on the rising clk_i edge.

Test Plan:
- 3-beat frame, DataWidth=32, tkeep 1111,1111,0011, tlast on beat 3 -> beats pass unchanged; next cycle len_valid_o=1, len_o=10, len_oversize_o=0, frame_cnt_o=1.
- Fill FIFO with 4 frames, len_ready_i=0, then present a 5th last beat -> s_tready_o=0, m_tvalid_o=0.
  - Pop one: stall holds in the pop cycle; the beat is accepted the cycle after.
  - fifo_level_o goes 4->3->4.
- LenWidth=4, frame of 5 full 4-byte beats (20 bytes) -> len_o=15, len_oversize_o=1; the next 2-byte frame gives len_o=2, oversize=0.
- Single beat, tkeep=0000, tlast=1 -> len_o=0 pushed; frame_cnt_o increments.
- Push and pop in the same cycle with level=2 -> level stays 2; popped values appear in push order.
- Mid-frame clear_i after 2 of 4 full beats -> FIFO empty, frame_cnt_o=0; the remaining 2 beats close a frame with len_o=8.
- Assert rst_i mid-frame -> all outputs return to reset values asynchronously, before any clock edge.
